// File: rtl/v810_fetch.sv
// V810 instruction fetch/prefetch stage: a halfword prefetch queue in front of
// v810_exec that assembles 16/32-bit instructions and honours branch redirects.
module v810_fetch #(
  parameter logic [31:0] RESET_PC = 32'hFFFF_FFF0,
  parameter int          QDEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  output logic [31:0] IA,
  input  logic [15:0] ID,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  output logic [31:0] INSN,
  output logic [31:0] INSN_PC,
  output logic        INSN_LONG,
  output logic        INSN_VALID,
  input  logic        INSN_READY
);

  localparam int              PW          = $clog2(QDEPTH);
  localparam int              CW          = $clog2(QDEPTH + 1);
  localparam logic [31:0]     RESET_PC_HW = RESET_PC & 32'hFFFF_FFFE;
  localparam logic [CW-1:0]   QFULL       = CW'(QDEPTH);

  // Opcodes 0x28..0x3F use the 32-bit format; everything else is 16-bit.
  function automatic logic is_long(input logic [15:0] hw);
    return (hw[15:13] == 3'b101) || (hw[15:14] == 2'b11);
  endfunction

  logic [15:0]   queue_r [QDEPTH];
  logic [31:0]   fetch_pc_r;
  logic [31:0]   head_pc_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] rd_ptr_r;

  logic [15:0]   hw0_s;
  logic [15:0]   hw1_s;
  logic          have1_s;
  logic          have2_s;
  logic          long_s;
  logic          valid_s;
  logic          pop_s;
  logic          push_s;
  logic [CW-1:0] pop_n_s;
  logic [CW-1:0] count_next_s;
  logic [PW-1:0] wr_ptr_s;

  // Queue head decode, pop/push decisions and next occupancy.
  always_comb begin
    hw0_s    = queue_r[rd_ptr_r];
    hw1_s    = queue_r[rd_ptr_r + PW'(1)];
    have1_s  = (count_r != CW'(0));
    have2_s  = (count_r >= CW'(2));
    long_s   = have1_s & is_long(hw0_s);
    valid_s  = have1_s & (~long_s | have2_s);
    // A redirect or reset overrides any pop or push in the same cycle.
    pop_s    = CE & ~RES & ~BR_TAKEN & valid_s & INSN_READY;
    push_s   = CE & ~RES & ~BR_TAKEN & ((count_r < QFULL) | pop_s);
    if (pop_s) begin
      pop_n_s = long_s ? CW'(2) : CW'(1);
    end else begin
      pop_n_s = CW'(0);
    end
    count_next_s = count_r - pop_n_s + (push_s ? CW'(1) : CW'(0));
    wr_ptr_s     = rd_ptr_r + count_r[PW-1:0];
  end

  // Instruction assembly towards the execute stage.
  always_comb begin
    IA         = fetch_pc_r;
    INSN_PC    = head_pc_r;
    INSN_LONG  = long_s;
    INSN_VALID = valid_s;
    if (!have1_s) begin
      INSN = 32'h0000_0000;
    end else if (long_s) begin
      INSN = {hw0_s, hw1_s};
    end else begin
      INSN = {hw0_s, 16'h0000};
    end
  end

  // Fetch/head pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (CE) begin
      if (RES) begin
        fetch_pc_r <= RESET_PC_HW;
        head_pc_r  <= RESET_PC_HW;
        count_r    <= CW'(0);
        rd_ptr_r   <= PW'(0);
      end else if (BR_TAKEN) begin
        fetch_pc_r <= BR_TARGET & 32'hFFFF_FFFE;
        head_pc_r  <= BR_TARGET & 32'hFFFF_FFFE;
        count_r    <= CW'(0);
        rd_ptr_r   <= PW'(0);
      end else begin
        if (push_s) begin
          fetch_pc_r <= fetch_pc_r + 32'd2;
        end
        if (pop_s) begin
          rd_ptr_r  <= rd_ptr_r + pop_n_s[PW-1:0];
          head_pc_r <= head_pc_r + (32'(pop_n_s) << 1);
        end
        count_r <= count_next_s;
      end
    end
  end

  // Queue storage; contents are don't-care outside the occupied window.
  always_ff @(posedge CLK) begin
    if (CE && push_s) begin
      queue_r[wr_ptr_s] <= ID;
    end
  end

  v810_fetch_chk #(.QDEPTH(QDEPTH), .CW(CW)) u_chk (
    .CLK        (CLK),
    .CE         (CE),
    .RES        (RES),
    .count_next (count_next_s)
  );

endmodule

// Simulation checker: the prefetch queue never overfills.
module v810_fetch_chk #(
  parameter int QDEPTH = 4,
  parameter int CW     = 3
) (
  input logic          CLK,
  input logic          CE,
  input logic          RES,
  input logic [CW-1:0] count_next
);

  a_no_overflow: assert property (@(posedge CLK) (CE && !RES) |-> (count_next <= CW'(QDEPTH)));

endmodule

// File: tb/tb_v810_fetch.sv
// Directed bench for v810_fetch: streaming, long assembly, back-pressure,
// redirect, address wrap and clock-enable hold.
module tb_v810_fetch;

  logic        clk = 1'b0;
  logic        res;
  logic        ce;
  logic        br_taken;
  logic [31:0] br_target;
  logic        insn_ready;
  logic [31:0] ia0;
  logic [15:0] id0;
  logic [31:0] insn0;
  logic [31:0] insn_pc0;
  logic        insn_long0;
  logic        insn_valid0;

  logic        res_w;
  logic        ce_w;
  logic        ready_w;
  logic [31:0] iaw;
  logic [15:0] idw;
  logic [31:0] insnw;
  logic [31:0] insn_pcw;
  logic        longw;
  logic        validw;

  logic [15:0] mem0 [128];
  logic [15:0] memw [128];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign id0 = mem0[ia0[7:1]];
  assign idw = memw[iaw[7:1]];

  v810_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut0 (
    .CLK        (clk),
    .RES        (res),
    .CE         (ce),
    .IA         (ia0),
    .ID         (id0),
    .BR_TAKEN   (br_taken),
    .BR_TARGET  (br_target),
    .INSN       (insn0),
    .INSN_PC    (insn_pc0),
    .INSN_LONG  (insn_long0),
    .INSN_VALID (insn_valid0),
    .INSN_READY (insn_ready)
  );

  v810_fetch #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(4)) dutw (
    .CLK        (clk),
    .RES        (res_w),
    .CE         (ce_w),
    .IA         (iaw),
    .ID         (idw),
    .BR_TAKEN   (1'b0),
    .BR_TARGET  (32'h0000_0000),
    .INSN       (insnw),
    .INSN_PC    (insn_pcw),
    .INSN_LONG  (longw),
    .INSN_VALID (validw),
    .INSN_READY (ready_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset0();
    res        = 1'b1;
    ce         = 1'b1;
    br_taken   = 1'b0;
    br_target  = 32'h0000_0000;
    tick();
    tick();
  endtask

  initial begin
    res        = 1'b1;
    ce         = 1'b1;
    br_taken   = 1'b0;
    br_target  = 32'h0000_0000;
    insn_ready = 1'b0;
    res_w      = 1'b1;
    ce_w       = 1'b1;
    ready_w    = 1'b0;
    for (int i = 0; i < 128; i++) begin
      mem0[i] = 16'h0000;
      memw[i] = 16'h0000;
    end

    // Short stream 0x0001..0x0008 from address 0.
    for (int i = 0; i < 8; i++) mem0[i] = 16'(i + 1);
    insn_ready = 1'b1;
    reset0();
    check("rst_ia",    ia0, 32'h0000_0000);
    check("rst_valid", 32'(insn_valid0), 32'd0);
    check("rst_insn",  insn0, 32'h0000_0000);
    check("rst_long",  32'(insn_long0), 32'd0);
    check("rst_pc",    insn_pc0, 32'h0000_0000);
    res = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("s_valid", 32'(insn_valid0), 32'd1);
      check("s_insn",  insn0, {16'(k + 1), 16'h0000});
      check("s_pc",    insn_pc0, 32'(2 * k));
      check("s_ia",    ia0, 32'(2 * (k + 1)));
    end

    // Short / long / short mix.
    for (int i = 0; i < 128; i++) mem0[i] = 16'h0000;
    mem0[0] = 16'h1C20;
    mem0[1] = 16'hA4A0;
    mem0[2] = 16'h1234;
    mem0[3] = 16'h0000;
    reset0();
    res = 1'b0;
    tick();
    check("m1_insn",  insn0, 32'h1C20_0000);
    check("m1_long",  32'(insn_long0), 32'd0);
    check("m1_pc",    insn_pc0, 32'h0000_0000);
    tick();
    check("m2_valid", 32'(insn_valid0), 32'd0);
    tick();
    check("m3_valid", 32'(insn_valid0), 32'd1);
    check("m3_insn",  insn0, 32'hA4A0_1234);
    check("m3_long",  32'(insn_long0), 32'd1);
    check("m3_pc",    insn_pc0, 32'h0000_0002);
    tick();
    check("m4_valid", 32'(insn_valid0), 32'd1);
    check("m4_pc",    insn_pc0, 32'h0000_0006);
    check("m4_long",  32'(insn_long0), 32'd0);

    // Back-pressure: queue fills to 4 and fetch stops at 8.
    for (int i = 0; i < 128; i++) mem0[i] = 16'(32'h0100 + i);
    insn_ready = 1'b0;
    reset0();
    res = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("bp_ia",    ia0, 32'h0000_0008);
    check("bp_valid", 32'(insn_valid0), 32'd1);
    check("bp_insn",  insn0, 32'h0100_0000);
    check("bp_pc",    insn_pc0, 32'h0000_0000);
    insn_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("dr_valid", 32'(insn_valid0), 32'd1);
      check("dr_insn",  insn0, {16'(32'h0100 + k), 16'h0000});
      check("dr_pc",    insn_pc0, 32'(2 * k));
    end

    // Redirect to 0x41 mid-stream.
    for (int i = 0; i < 128; i++) begin
      if (i < 32) mem0[i] = 16'(32'h0200 + i);
      else        mem0[i] = 16'(32'h0300 + i - 32);
    end
    insn_ready = 1'b1;
    reset0();
    res = 1'b0;
    tick();
    tick();
    tick();
    check("br_pre_insn", insn0, 32'h0202_0000);
    br_taken  = 1'b1;
    br_target = 32'h0000_0041;
    tick();
    br_taken  = 1'b0;
    check("br_ia",     ia0, 32'h0000_0040);
    check("br_valid0", 32'(insn_valid0), 32'd0);
    tick();
    check("br_valid1", 32'(insn_valid0), 32'd1);
    check("br_insn1",  insn0, 32'h0300_0000);
    check("br_pc1",    insn_pc0, 32'h0000_0040);
    tick();
    check("br_insn2",  insn0, 32'h0301_0000);
    check("br_pc2",    insn_pc0, 32'h0000_0042);

    // Address wrap with a long instruction at 0xFFFF_FFFE.
    memw[7'h7E] = 16'h0011;
    memw[7'h7F] = 16'hB000;
    memw[7'h00] = 16'h5678;
    memw[7'h01] = 16'h0022;
    ready_w = 1'b1;
    tick();
    check("w_rst_ia",    iaw, 32'hFFFF_FFFC);
    check("w_rst_valid", 32'(validw), 32'd0);
    res_w = 1'b0;
    tick();
    check("w1_insn", insnw, 32'h0011_0000);
    check("w1_pc",   insn_pcw, 32'hFFFF_FFFC);
    tick();
    check("w2_valid", 32'(validw), 32'd0);
    check("w2_ia",    iaw, 32'h0000_0000);
    tick();
    check("w3_valid", 32'(validw), 32'd1);
    check("w3_insn",  insnw, 32'hB000_5678);
    check("w3_long",  32'(longw), 32'd1);
    check("w3_pc",    insn_pcw, 32'hFFFF_FFFE);
    tick();
    check("w4_insn",  insnw, 32'h0022_0000);
    check("w4_pc",    insn_pcw, 32'h0000_0002);

    // CE toggling: same sequence as the plain short stream, held while CE=0.
    for (int i = 0; i < 128; i++) mem0[i] = 16'h0000;
    for (int i = 0; i < 8; i++) mem0[i] = 16'(i + 1);
    insn_ready = 1'b1;
    reset0();
    res = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ce = 1'b1;
      tick();
      check("ce_insn", insn0, {16'(k + 1), 16'h0000});
      check("ce_pc",   insn_pc0, 32'(2 * k));
      ce = 1'b0;
      tick();
      check("ce_hold_valid", 32'(insn_valid0), 32'd1);
      check("ce_hold_insn",  insn0, {16'(k + 1), 16'h0000});
      check("ce_hold_pc",    insn_pc0, 32'(2 * k));
      check("ce_hold_ia",    ia0, 32'(2 * (k + 1)));
    end
    ce = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
